shift_ctrl: RTL
===============

// Module: shift_ctrl
// PURPOSE
//  Upstream control stage for the 43-bit left/right shift register (lab6).
//  Debounces the start/stop buttons and the direction switch, and generates a
//  periodic one-cycle step_tick. Drives the shifter's enable (0 = load
//  start_value, 1 = shift) and shift_switch (1 = right by 3, 0 = left by 1).
//  Consumes the shifter's current value for optional auto-stop at zero.
// PARAMETERS
//  WIDTH   43  width of the observed shifter value
//  DIV_W   24  width of the step-period counter / period input
//  DEB_CYC 16  consecutive stable cycles before a debounced input changes (>=2)
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst_n        in   1        asynchronous active-low reset
//  btn_start    in   1        raw start/resume button, active-high, asynchronous
//  btn_stop     in   1        raw stop/pause button, active-high, asynchronous
//  sw_dir       in   1        raw direction switch: 1 = right, 0 = left
//  period       in   DIV_W    clk cycles per step; 0 is treated as 1
//  shift_value  in   WIDTH    shifter out_value, fed back
//  step_tick    out  1        one-cycle pulse; the shifter advances on it
//  enable       out  1        to shifter: 0 = load, 1 = shift
//  shift_switch out  1        to shifter: direction
//  running      out  1        high in RUN
//  done         out  1        high in DONE (auto-stop only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0.
//  - Inputs: 2-flop synchroniser, then debounce. A debounced value changes only
//    after DEB_CYC consecutive equal synchronised samples. start_p/stop_p =
//    one-cycle pulse on the debounced rising edge.
//  - Tick gen: counter runs in IDLE, LOAD and RUN; it is held at 0 in PAUSE/DONE.
//    step_tick=1 when cnt==max(period,1)-1, then cnt<=0.
//    period change takes effect at the next wrap. If cnt>=new period-1, wrap on
//    the next cycle.
//  - shift_switch <= debounced sw_dir, updated only in the cycle after a
//    step_tick, so it is stable for a whole step.
//  - FSM (stop_p beats start_p when both arrive in one cycle):
//    IDLE : enable=0. start_p -> LOAD.
//    LOAD : enable=0 until the first step_tick in LOAD (the shifter loads), then -> RUN.
//    RUN  : enable=1, running=1. stop_p -> PAUSE.
//    PAUSE: enable=1, no ticks (value held). start_p -> RUN; stop_p -> IDLE.
//    DONE : enable=1, done=1, no ticks. start_p -> LOAD; stop_p -> IDLE.
//  - Outputs are registered; state decode appears 1 cycle after the transition.
//  - Reset mid-RUN: immediate return to IDLE with enable=0; no step_tick is
//    emitted in the reset-release cycle.
// CONFIGURATION
//  SHIFT_CTRL_AUTOSTOP_EN defined: in RUN, on a step_tick cycle with
//    shift_value==0 -> DONE (the tick is still emitted; no ticks follow).
//  Not defined: DONE is unreachable and done is tied 0. shift_value is unused
//    (lint waiver).
// STRUCTURE
//  shift_ctrl_pkg: state encoding localparams (IDLE, LOAD, RUN, PAUSE, DONE;
//    3-bit), DIR_LEFT/DIR_RIGHT constants.
//  Sub-module btn_debounce (sync + counter + stable output), instantiated 3x.
//    shift_ctrl keeps the edge detect, tick gen and FSM.
// TESTING (DEB_CYC=4, period=5)
//  1 Reset mid-RUN: assert rst_n=0 -> all outputs 0 in the same cycle; IDLE after release.
//  2 start held 6 cycles -> LOAD; enable=0 through the first tick; then RUN,
//    ticks every 5 clk.
//  3 3-cycle start glitch -> no state change. stop during RUN -> PAUSE, no ticks.
//    start -> RUN resumes.
//  4 sw_dir toggled mid-step -> shift_switch changes exactly 1 cycle after the next tick.
//  5 period=0 -> tick every cycle. period 5->2 with cnt=4 -> wrap next cycle.
//  6 AUTOSTOP_EN: shift_value=0 at a tick -> DONE, done=1, no ticks. start -> LOAD.
//    Without the macro: same stimulus stays in RUN.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shifter control stage: FSM state codes and
// shifter direction values.
package shift_ctrl_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // The step counter only advances in states where the shifter may be stepped.
    function automatic logic ticks_allowed(input logic [2:0] st);
        return (st == IDLE) || (st == LOAD) || (st == RUN);
    endfunction

endpackage

// File: rtl/shift_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output follows
// the synchronised input only after DEB_CYC consecutive differing samples.
module btn_debounce
    import shift_ctrl_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          stable_r;

    // Synchronise the raw input and count how long it has disagreed with the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b00;
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], din};
            if (sync_r[1] == stable_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync_r[1];
                cnt_r    <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign dout = stable_r;

endmodule

// File: rtl/shift_ctrl.sv
// Control stage for the 43-bit left/right shifter: button debounce, step tick
// generation and the run/pause FSM. SHIFT_CTRL_AUTOSTOP_EN enables auto-stop at zero.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH   = 43,
    parameter int DIV_W   = 24,
    parameter int DEB_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             sw_dir,
    input  logic [DIV_W-1:0] period,
    input  logic [WIDTH-1:0] shift_value,
    output logic             step_tick,
    output logic             enable,
    output logic             shift_switch,
    output logic             running,
    output logic             done
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       rst_sync_r;
    logic             rst_int_n_s;
    logic             start_db_s, stop_db_s, dir_db_s;
    logic             start_q_r, stop_q_r;
    logic             start_p_s, stop_p_s;
    logic [2:0]       state_r, state_next_s;
    logic [DIV_W-1:0] cnt_r, period_eff_s;
    logic             step_tick_r;
    logic             enable_r, running_r, done_r, shift_switch_r;
    logic             enable_next_s, running_next_s, done_next_s;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_int_n_s = rst_sync_r[1];

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
        .clk(clk), .rst_n(rst_int_n_s), .din(btn_start), .dout(start_db_s));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_stop (
        .clk(clk), .rst_n(rst_int_n_s), .din(btn_stop), .dout(stop_db_s));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dir (
        .clk(clk), .rst_n(rst_int_n_s), .din(sw_dir), .dout(dir_db_s));

    // Previous debounced button levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            start_q_r <= 1'b0;
            stop_q_r  <= 1'b0;
        end else begin
            start_q_r <= start_db_s;
            stop_q_r  <= stop_db_s;
        end
    end
    assign start_p_s = start_db_s & ~start_q_r;
    assign stop_p_s  = stop_db_s & ~stop_q_r;

    assign period_eff_s = (period == {DIV_W{1'b0}}) ? DIV_ONE : period;

    // Step counter; gated by the next state so no tick appears once PAUSE/DONE is entered.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            cnt_r       <= {DIV_W{1'b0}};
            step_tick_r <= 1'b0;
        end else if (!ticks_allowed(state_next_s)) begin
            cnt_r       <= {DIV_W{1'b0}};
            step_tick_r <= 1'b0;
        end else if (cnt_r >= period_eff_s - DIV_ONE) begin
            cnt_r       <= {DIV_W{1'b0}};
            step_tick_r <= 1'b1;
        end else begin
            cnt_r       <= cnt_r + DIV_ONE;
            step_tick_r <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; stop wins over start when both arrive together.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_p_s) state_next_s = LOAD;
                else           state_next_s = IDLE;
            end
            LOAD: begin
                if (step_tick_r) state_next_s = RUN;
                else             state_next_s = LOAD;
            end
            RUN: begin
                if (stop_p_s) state_next_s = PAUSE;
`ifdef SHIFT_CTRL_AUTOSTOP_EN
                else if (step_tick_r && (shift_value == {WIDTH{1'b0}})) state_next_s = DONE;
`endif
                else          state_next_s = RUN;
            end
            PAUSE: begin
                if (stop_p_s)       state_next_s = IDLE;
                else if (start_p_s) state_next_s = RUN;
                else                state_next_s = PAUSE;
            end
            DONE: begin
                if (stop_p_s)       state_next_s = IDLE;
                else if (start_p_s) state_next_s = LOAD;
                else                state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode of the upcoming state, so registered outputs track state_r.
    always_comb begin
        enable_next_s  = 1'b0;
        running_next_s = 1'b0;
        done_next_s    = 1'b0;
        case (state_next_s)
            IDLE:    enable_next_s = 1'b0;
            LOAD:    enable_next_s = 1'b0;
            RUN: begin
                enable_next_s  = 1'b1;
                running_next_s = 1'b1;
            end
            PAUSE:   enable_next_s = 1'b1;
            DONE: begin
                enable_next_s = 1'b1;
`ifdef SHIFT_CTRL_AUTOSTOP_EN
                done_next_s   = 1'b1;
`else
                done_next_s   = 1'b0;
`endif
            end
            default: enable_next_s = 1'b0;
        endcase
    end

    // Output registers; direction is sampled only right after a tick so it holds for a step.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            enable_r       <= 1'b0;
            running_r      <= 1'b0;
            done_r         <= 1'b0;
            shift_switch_r <= DIR_LEFT;
        end else begin
            enable_r  <= enable_next_s;
            running_r <= running_next_s;
            done_r    <= done_next_s;
            if (step_tick_r) begin
                shift_switch_r <= (dir_db_s == DIR_RIGHT) ? DIR_RIGHT : DIR_LEFT;
            end else begin
                shift_switch_r <= shift_switch_r;
            end
        end
    end

`ifndef SHIFT_CTRL_AUTOSTOP_EN
    logic unused_shift_value_s;
    assign unused_shift_value_s = ^shift_value;
`endif

    assign step_tick    = step_tick_r;
    assign enable       = enable_r;
    assign running      = running_r;
    assign done         = done_r;
    assign shift_switch = shift_switch_r;

endmodule
